// File: rtl/adc_capture_ctrl_if.sv
// AXI-Stream channel carrying captured ADC words out of the capture stage.
//   tdata  : DATA_W-bit word (8 x 16-bit samples, sample 0 in [15:0])
//   tvalid : output register holds a word
//   tready : downstream FIFO can accept a word
//   tlast  : final word of a capture
// master = capture stage (adc_capture_ctrl), slave = downstream FIFO.
interface adc_capture_ctrl_if #(
  parameter int DATA_W = 128
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_capture_ctrl.sv
// Triggered ADC capture stage. Watches a free-running, unstallable ADC word
// stream, and after arm + trigger forwards exactly num_words words through a
// single-entry AXI-Stream output register. Words that cannot be stored
// because the register is full and downstream is not ready are dropped and
// flagged in a sticky overflow bit.
// Ports:
//   pl_clk, rst     : clock, asynchronous active-high reset
//   s_adc_tdata/
//   s_adc_tvalid    : ADC word stream (no backpressure possible)
//   arm             : pulse, accepted in IDLE; latches num_words
//   trigger         : level, sampled in ARMED together with s_adc_tvalid
//   abort           : pulse, returns to IDLE from any state, no done
//   num_words       : capture length (0 = immediate done)
//   m_axis          : AXI-Stream master (tdata/tvalid/tready/tlast)
//   busy            : high in ARMED, CAPTURE, FLUSH
//   done            : one-cycle pulse when the capture has fully drained
//   overflow        : sticky drop flag, cleared on the next accepted arm
module adc_capture_ctrl #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              pl_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_adc_tdata,
  input  logic              s_adc_tvalid,
  input  logic              arm,
  input  logic              trigger,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_words,
  adc_capture_ctrl_if.master m_axis,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  nw_q;     // latched capture length
  logic [CNT_W-1:0]  cnt;      // words still to capture, including the current one
  logic [DATA_W-1:0] tdata_p1;
  logic              vld_p1;
  logic              tlast_p1;

  logic cap_word;
  logic is_last;
  logic can_load;
  logic load;
  logic drop;

  // Input side: decide whether this cycle's ADC word belongs to the capture
  // window and whether it is the final one. In ARMED the trigger word is
  // word 0, so it is last only for a one-word capture.
  always_comb begin
    cap_word = s_adc_tvalid &&
               (((state == ARMED) && trigger) || (state == CAPTURE));
    is_last  = (state == ARMED) ? (nw_q == CNT_W'(1)) : (cnt == CNT_W'(1));
    can_load = !vld_p1 || m_axis.tready;
    load     = cap_word && can_load;
    drop     = cap_word && !can_load;
  end

  assign m_axis.tdata  = tdata_p1;
  assign m_axis.tvalid = vld_p1;
  assign m_axis.tlast  = tlast_p1;

  always_ff @(posedge pl_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      nw_q     <= '0;
      cnt      <= '0;
      tdata_p1 <= '0;
      vld_p1   <= 1'b0;
      tlast_p1 <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        vld_p1   <= 1'b0;
        tlast_p1 <= 1'b0;
      end else begin
        // ---- stage p1: output register (load/drain, drop handling) ----
        if (load) begin
          tdata_p1 <= s_adc_tdata;
          vld_p1   <= 1'b1;
          tlast_p1 <= is_last;
        end else if (vld_p1 && m_axis.tready) begin
          vld_p1   <= 1'b0;
          tlast_p1 <= 1'b0;
        end
        // A dropped final word still has to terminate the packet, so its
        // tlast is moved onto the word being held.
        if (drop) begin
          overflow <= 1'b1;
          if (is_last) begin
            tlast_p1 <= 1'b1;
          end
        end

        case (state)
          IDLE: begin
            if (arm) begin
              overflow <= 1'b0;
              nw_q     <= num_words;
              if (num_words == '0) begin
                done <= 1'b1;
              end else begin
                state <= ARMED;
                busy  <= 1'b1;
              end
            end
          end
          ARMED: begin
            if (trigger && s_adc_tvalid) begin
              cnt   <= nw_q - CNT_W'(1);
              state <= (nw_q == CNT_W'(1)) ? FLUSH : CAPTURE;
            end
          end
          CAPTURE: begin
            // The window is time-fixed: dropped words still count.
            if (s_adc_tvalid) begin
              cnt <= cnt - CNT_W'(1);
              if (cnt == CNT_W'(1)) begin
                state <= FLUSH;
              end
            end
          end
          FLUSH: begin
            if (!vld_p1) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
module tb_adc_capture_ctrl;
  localparam int DW = 128;
  localparam int CW = 16;

  logic          pl_clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_adc_tdata;
  logic          s_adc_tvalid;
  logic          arm;
  logic          trigger;
  logic          abort;
  logic [CW-1:0] num_words;
  logic          busy;
  logic          done;
  logic          overflow;

  adc_capture_ctrl_if #(.DATA_W(DW)) m_axis_bus ();

  adc_capture_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .pl_clk       (pl_clk),
    .rst          (rst),
    .s_adc_tdata  (s_adc_tdata),
    .s_adc_tvalid (s_adc_tvalid),
    .arm          (arm),
    .trigger      (trigger),
    .abort        (abort),
    .num_words    (num_words),
    .m_axis       (m_axis_bus),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  always #5 pl_clk = ~pl_clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit auto_chk = 1'b0;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] word_of(int k);
    logic [DW-1:0] w;
    w = '0;
    for (int s = 0; s < 8; s++) w[s*16 +: 16] = 16'((7 - s) * 32'h1111 + k * 32'h8888);
    return w;
  endfunction

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [DW-1:0] d; bit l; } ent_t;
  ent_t        m_out[$];   // contents of the one-deep output register
  bit          m_armed, m_flush, m_done, m_ovf, m_busy;
  int          m_left;     // capture words still expected
  int unsigned m_nw;

  task automatic model_reset();
    m_out.delete();
    m_armed = 0; m_flush = 0; m_done = 0; m_ovf = 0; m_busy = 0;
    m_left = 0; m_nw = 0;
  endtask

  task automatic model_step();
    bit idle, empty, take, last;
    ent_t e;
    idle  = !m_armed && (m_left == 0) && !m_flush;
    empty = (m_out.size() == 0);
    m_done = 0;
    if (abort) begin
      m_armed = 0; m_left = 0; m_flush = 0;
      m_out.delete();
    end else begin
      if (!empty && m_axis_bus.tready) void'(m_out.pop_front());
      take = 0;
      if (m_armed && trigger && s_adc_tvalid) begin
        m_armed = 0; m_left = m_nw; take = 1;
      end else if (m_left > 0 && s_adc_tvalid) begin
        take = 1;
      end
      if (take) begin
        last = (m_left == 1);
        m_left--;
        if (m_out.size() == 0) begin
          e.d = s_adc_tdata; e.l = last;
          m_out.push_back(e);
        end else begin
          m_ovf = 1;
          if (last) m_out[0].l = 1;
        end
        if (last) m_flush = 1;
      end else if (m_flush && empty) begin
        m_flush = 0; m_done = 1;
      end
      if (idle && arm) begin
        m_ovf = 0;
        if (num_words == 0) m_done = 1;
        else begin m_armed = 1; m_nw = num_words; end
      end
    end
    m_busy = m_armed || (m_left > 0) || m_flush;
  endtask

  task automatic check_model(string name);
    logic [255:0] act, exp;
    bit ev;
    ev  = (m_out.size() > 0);
    act = 256'({m_axis_bus.tvalid, m_axis_bus.tvalid & m_axis_bus.tlast, busy, done, overflow,
                (m_axis_bus.tvalid ? m_axis_bus.tdata : {DW{1'b0}})});
    exp = 256'({ev, ev ? m_out[0].l : 1'b0, m_busy, m_done, m_ovf,
                (ev ? m_out[0].d : {DW{1'b0}})});
    check(name, act, exp);
  endtask

  task automatic drive(bit a, bit t, bit v, bit r, bit ab, logic [CW-1:0] nw, logic [DW-1:0] d);
    arm = a; trigger = t; s_adc_tvalid = v; m_axis_bus.tready = r;
    abort = ab; num_words = nw; s_adc_tdata = d;
  endtask

  task automatic tick();
    if (rst) model_reset(); else model_step();
    @(posedge pl_clk);
    #1;
    if (auto_chk) check_model("model");
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit arm, trig, tv, rdy;
    logic [CW-1:0] nw;
    int wi;
    bit e_v, e_l;
    int e_wi;
    bit e_busy, e_done, e_ovf;
  } vec_t;
  vec_t tbl[$];

  int words, seen;

  initial begin
    // arm trig tv rdy nw wi | v l wi busy done ovf
    // basic 4-word capture with tready high
    tbl.push_back(vec_t'{1,0,0,1,4,-1, 0,0,0, 1,0,0});
    tbl.push_back(vec_t'{0,0,1,1,4, 9, 0,0,0, 1,0,0});
    tbl.push_back(vec_t'{0,1,1,1,4, 0, 1,0,0, 1,0,0});
    tbl.push_back(vec_t'{1,0,1,1,4, 1, 1,0,1, 1,0,0});
    tbl.push_back(vec_t'{0,0,1,1,4, 2, 1,0,2, 1,0,0});
    tbl.push_back(vec_t'{0,0,1,1,4, 3, 1,1,3, 1,0,0});
    tbl.push_back(vec_t'{0,0,0,1,4,-1, 0,0,0, 1,0,0});
    tbl.push_back(vec_t'{0,0,0,1,4,-1, 0,0,0, 0,1,0});
    tbl.push_back(vec_t'{0,0,0,1,4,-1, 0,0,0, 0,0,0});
    // zero-length arm, then trigger while idle
    tbl.push_back(vec_t'{1,0,0,1,0,-1, 0,0,0, 0,1,0});
    tbl.push_back(vec_t'{0,0,0,1,0,-1, 0,0,0, 0,0,0});
    tbl.push_back(vec_t'{0,1,1,1,0, 4, 0,0,0, 0,0,0});
    // tready low throughout capture: word 0 held, rest dropped
    tbl.push_back(vec_t'{1,0,0,0,4,-1, 0,0,0, 1,0,0});
    tbl.push_back(vec_t'{0,1,1,0,4, 5, 1,0,5, 1,0,0});
    tbl.push_back(vec_t'{0,1,1,0,4, 6, 1,0,5, 1,0,1});
    tbl.push_back(vec_t'{0,1,1,0,4, 7, 1,0,5, 1,0,1});
    tbl.push_back(vec_t'{0,1,1,0,4, 8, 1,1,5, 1,0,1});
    tbl.push_back(vec_t'{0,0,1,0,4, 9, 1,1,5, 1,0,1});
    tbl.push_back(vec_t'{0,0,0,1,4,-1, 0,0,0, 1,0,1});
    tbl.push_back(vec_t'{0,0,0,1,4,-1, 0,0,0, 0,1,1});
    tbl.push_back(vec_t'{0,0,0,1,4,-1, 0,0,0, 0,0,1});
    // single-word capture; arm clears overflow
    tbl.push_back(vec_t'{1,0,0,1,1,-1, 0,0,0, 1,0,0});
    tbl.push_back(vec_t'{0,1,1,1,1,10, 1,1,10, 1,0,0});
    tbl.push_back(vec_t'{0,0,0,1,1,-1, 0,0,0, 1,0,0});
    tbl.push_back(vec_t'{0,0,0,1,1,-1, 0,0,0, 0,1,0});
    tbl.push_back(vec_t'{0,0,0,1,1,-1, 0,0,0, 0,0,0});

    rst = 1'b1;
    drive(0, 0, 0, 1, 0, '0, '0);
    model_reset();
    repeat (3) @(posedge pl_clk);
    #1;
    check("reset_state", 256'({m_axis_bus.tvalid, m_axis_bus.tlast, busy, done, overflow,
                               m_axis_bus.tdata}), '0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].arm, tbl[i].trig, tbl[i].tv, tbl[i].rdy, 1'b0, tbl[i].nw,
            (tbl[i].wi < 0) ? {DW{1'b0}} : word_of(tbl[i].wi));
      tick();
      check($sformatf("vec%0d", i),
            256'({m_axis_bus.tvalid, m_axis_bus.tvalid & m_axis_bus.tlast, busy, done, overflow,
                  (m_axis_bus.tvalid ? m_axis_bus.tdata : {DW{1'b0}})}),
            256'({tbl[i].e_v, tbl[i].e_l, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_ovf,
                  (tbl[i].e_v ? word_of(tbl[i].e_wi) : {DW{1'b0}})}));
    end

    auto_chk = 1'b1;

    // long trigger wait, then capture with s_adc_tvalid gaps
    begin
      logic [DW-1:0] d0;
      drive(1, 0, 0, 1, 0, 5, '0); tick();
      repeat (50) begin drive(0, 0, bit'($urandom_range(0, 1)), 1, 0, 5, rnd()); tick(); end
      d0 = rnd();
      drive(0, 1, 1, 1, 0, 5, d0); tick();
      check("trig_word0", 256'({m_axis_bus.tvalid, m_axis_bus.tdata}), 256'({1'b1, d0}));
      words = 1; seen = 0;
      for (int k = 0; k < 60 && seen == 0; k++) begin
        drive(0, 1, bit'($urandom_range(0, 1)), 1, 0, 5, rnd()); tick();
        if (m_axis_bus.tvalid) words++;
        if (done) seen = 1;
      end
      check("gap_count", 256'(words), 256'(5));
      check("gap_done", 256'(seen), 256'(1));
    end

    // abort after 2 of 8 words, coincident with arm; then rearm
    drive(1, 0, 0, 1, 0, 8, '0); tick();
    drive(0, 1, 1, 1, 0, 8, rnd()); tick();
    drive(0, 0, 1, 1, 0, 8, rnd()); tick();
    drive(1, 0, 1, 1, 1, 8, rnd()); tick();
    check("abort_tvalid", 256'(m_axis_bus.tvalid), '0);
    check("abort_busy", 256'(busy), '0);
    seen = 0;
    repeat (10) begin drive(0, 0, 1, 1, 0, 8, rnd()); tick(); if (done) seen++; end
    check("abort_nodone", 256'(seen), '0);
    drive(1, 0, 0, 1, 0, 3, '0); tick();
    seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      drive(0, 1, 1, 1, 0, 3, rnd()); tick();
      if (done) seen = 1;
    end
    check("rearm_done", 256'(seen), 256'(1));

    // asynchronous reset between clock edges mid-capture
    drive(1, 0, 0, 0, 0, 8, '0); tick();
    drive(0, 1, 1, 0, 0, 8, rnd()); tick();
    drive(0, 0, 1, 0, 0, 8, rnd()); tick();
    drive(0, 0, 1, 0, 0, 8, rnd()); tick();
    #3 rst = 1'b1;
    #1;
    check("async_rst", 256'({m_axis_bus.tvalid, m_axis_bus.tlast, busy, done, overflow,
                             m_axis_bus.tdata}), '0);
    drive(0, 0, 0, 1, 0, 0, '0);
    tick();
    rst = 1'b0;

    // randomized traffic against the reference model
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0,
            CW'($urandom_range(0, 6)), rnd());
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
